// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy flags and error flags.
// Optional macro FIFO_STICKY_ERR_EN makes over/under hold until reset.
module sync_fifo #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             almostfull,
    output logic             full,
    output logic             over,
    output logic             empty,
    output logic             under,
    output logic             valid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             valid_q,  valid_d;
    logic             over_q,   over_d;
    logic             under_q,  under_d;

    logic             wr_ok;
    logic             rd_ok;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        almostfull = (count_q >= CW'(AF_LEVEL));
    end

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_ok = rd && !empty;
        wr_ok = wr && (!full || rd_ok);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
        end

        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
`ifdef FIFO_STICKY_ERR_EN
        over_d  = over_q  | (wr && !wr_ok);
        under_d = under_q | (rd && !rd_ok);
`else
        over_d  = wr && !wr_ok;
        under_d = rd && !rd_ok;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            over_q   <= over_d;
            under_q  <= under_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign over  = over_q;
    assign under = under_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, async-reset sequence,
// and randomized traffic compared against a queue-based reference model.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFL   = 7;

    logic             clk;
    logic             rst;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             almostfull;
    logic             full;
    logic             over;
    logic             empty;
    logic             under;
    logic             valid;

    int total = 0;
    int bad   = 0;

    sync_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AFL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .rd        (rd),
        .din       (din),
        .dout      (dout),
        .almostfull(almostfull),
        .full      (full),
        .over      (over),
        .empty     (empty),
        .under     (under),
        .valid     (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             w;
        logic             r;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e_dout;
        logic             e_valid;
        logic             e_empty;
        logic             e_full;
        logic             e_af;
        logic             e_over;
        logic             e_under;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_over;
    logic             m_under;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] e_dout, input logic e_valid, input logic e_empty,
                       input logic e_full, input logic e_af, input logic e_over, input logic e_under);
        vec_t v;
        v.w = w; v.r = r; v.d = d;
        v.e_dout = e_dout; v.e_valid = e_valid; v.e_empty = e_empty;
        v.e_full = e_full; v.e_af = e_af; v.e_over = e_over; v.e_under = e_under;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        @(negedge clk);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        bit rd_acc;
        bit wr_acc;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        rd_acc    = r && !was_empty;
        wr_acc    = w && (!was_full || rd_acc);
        m_valid   = rd_acc;
        if (rd_acc) m_dout = mq.pop_front();
        if (wr_acc) mq.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
        m_over  = m_over  | (w && !wr_acc);
        m_under = m_under | (r && !rd_acc);
`else
        m_over  = w && !wr_acc;
        m_under = r && !rd_acc;
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        wr  = 1'b0;
        rd  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic seen_over;
        logic seen_under;
        logic exp_o;
        logic exp_u;
        int   n;

        wr = 1'b0; rd = 1'b0; din = '0; rst = 1'b0;

        // Fill 1..9 with the 9th rejected
        for (int i = 1; i <= 9; i++)
            add(1'b1, 1'b0, WIDTH'(i), '0, 1'b0, 1'b0, 1'b1 ? (i >= 8) : 1'b0, (i >= 7), (i == 9), 1'b0);
        // Drain 9 reads, the 9th underflows
        for (int j = 1; j <= 8; j++)
            add(1'b0, 1'b1, '0, WIDTH'(j), 1'b1, (j == 8), 1'b0, (j == 1), 1'b0, 1'b0);
        add(1'b0, 1'b1, '0, 16'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Refill with 0x101..0x108
        for (int k = 1; k <= 8; k++)
            add(1'b1, 1'b0, WIDTH'(16'h100 + k), 16'd8, 1'b0, 1'b0, (k == 8), (k >= 7), 1'b0, 1'b0);
        // Simultaneous access while full
        add(1'b1, 1'b1, 16'hAAAA, 16'h0101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int m = 1; m <= 8; m++)
            add(1'b0, 1'b1, '0, (m == 8) ? 16'hAAAA : WIDTH'(16'h101 + m), 1'b1,
                (m == 8), 1'b0, (m == 1), 1'b0, 1'b0);
        // Simultaneous access while empty, then read back the written word
        add(1'b1, 1'b1, 16'h1234, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, '0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full",  32'(full),  32'd0);
        chk("rst af",    32'(almostfull), 32'd0);
        chk("rst over",  32'(over),  32'd0);
        chk("rst under", 32'(under), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst dout",  32'(dout),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        chk("idle empty", 32'(empty), 32'd1);
        chk("idle valid", 32'(valid), 32'd0);
        chk("idle dout",  32'(dout),  32'd0);

        seen_over  = 1'b0;
        seen_under = 1'b0;
        foreach (vecs[i]) begin
            step(vecs[i].w, vecs[i].r, vecs[i].d);
            exp_o = vecs[i].e_over;
            exp_u = vecs[i].e_under;
`ifdef FIFO_STICKY_ERR_EN
            exp_o = exp_o | seen_over;
            exp_u = exp_u | seen_under;
`endif
            seen_over  = seen_over  | vecs[i].e_over;
            seen_under = seen_under | vecs[i].e_under;
            chk($sformatf("row%0d dout",  i), 32'(dout),       32'(vecs[i].e_dout));
            chk($sformatf("row%0d valid", i), 32'(valid),      32'(vecs[i].e_valid));
            chk($sformatf("row%0d empty", i), 32'(empty),      32'(vecs[i].e_empty));
            chk($sformatf("row%0d full",  i), 32'(full),       32'(vecs[i].e_full));
            chk($sformatf("row%0d af",    i), 32'(almostfull), 32'(vecs[i].e_af));
            chk($sformatf("row%0d over",  i), 32'(over),       32'(exp_o));
            chk($sformatf("row%0d under", i), 32'(under),      32'(exp_u));
        end

        // Asynchronous reset between clock edges after 5 writes
        pulse_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(16'h0500 + i));
        chk("pre-arst empty", 32'(empty), 32'd0);
        @(negedge clk);
        wr = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst empty", 32'(empty), 32'd1);
        chk("arst full",  32'(full),  32'd0);
        chk("arst af",    32'(almostfull), 32'd0);
        chk("arst dout",  32'(dout),  32'd0);
        chk("arst valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        // Stored data must be gone: a read now underflows
        step(1'b0, 1'b1, '0);
        chk("post-arst under", 32'(under), 32'd1);
        chk("post-arst valid", 32'(valid), 32'd0);
        chk("post-arst dout",  32'(dout),  32'd0);
        step(1'b1, 1'b0, 16'h7777);
`ifdef FIFO_STICKY_ERR_EN
        chk("sticky under 1", 32'(under), 32'd1);
        repeat (3) step(1'b0, 1'b0, '0);
        chk("sticky under 2", 32'(under), 32'd1);
`else
        chk("pulse under clr", 32'(under), 32'd0);
`endif
        chk("post-arst count1", 32'(empty), 32'd0);

        // Randomized traffic against the queue model, in phases biased toward full/empty
        pulse_reset();
        n = 0;
        for (int p = 0; p < 4; p++) begin
            int unsigned pw;
            int unsigned pr;
            case (p)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                2:       begin pw = 50; pr = 50; end
                default: begin pw = 90; pr = 90; end
            endcase
            for (int c = 0; c < 150; c++) begin
                logic             w;
                logic             r;
                logic [WIDTH-1:0] d;
                w = ($urandom_range(99) < pw);
                r = ($urandom_range(99) < pr);
                d = WIDTH'($urandom);
                step(w, r, d);
                model_step(w, r, d);
                n++;
                chk($sformatf("rnd%0d dout",  n), 32'(dout),       32'(m_dout));
                chk($sformatf("rnd%0d valid", n), 32'(valid),      32'(m_valid));
                chk($sformatf("rnd%0d empty", n), 32'(empty),      32'(mq.size() == 0));
                chk($sformatf("rnd%0d full",  n), 32'(full),       32'(mq.size() == DEPTH));
                chk($sformatf("rnd%0d af",    n), 32'(almostfull), 32'(mq.size() >= AFL));
                chk($sformatf("rnd%0d over",  n), 32'(over),       32'(m_over));
                chk($sformatf("rnd%0d under", n), 32'(under),      32'(m_under));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
